uart_tx_fifo_feeder: RTL
========================

# uart_tx_fifo_feeder

Byte buffer and handshake sequencer sitting directly upstream of the UART transmit controller. A producer, such as a message formatter or a debug dump engine, writes bytes at system-clock rate into a 16-entry FIFO. The block pops one byte at a time and presents it on `TX_data` with a `Start` request. It holds the byte stable until the controller's `Empty` flag shows the frame is finished, so back-to-back bytes go out with no producer involvement.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `Clock`  in  1  system clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset. The top level drives the controller's `Resetn` from `~Reset`.
- `Write_en`  in  1  producer write strobe, one byte per cycle.
- `Write_data`  in  8  byte to enqueue.
- `Full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `Count`  out  DEPTH_LOG2+1  number of bytes currently stored, 0..16.
- `Overflow`  out  1  sticky flag, set when a write is dropped.
- `Clear_overflow`  in  1  clears `Overflow`.
- `TX_empty`  in  1  `Empty` output of the transmit controller.
- `Start`  out  1  transmit request to the controller.
- `TX_data`  out  8  byte being transmitted; held for the whole frame.
- `Busy`  out  1  sequencer is not in S_FEED_IDLE.

## Operation
- FIFO is a circular buffer with read and write pointers of DEPTH_LOG2 bits each; both pointers wrap modulo 16.
- The separate `Count` register disambiguates full from empty.
- **Write:** when `Write_en && !Full`, store `Write_data` at the write pointer and increment the pointer.
- **Dropped write:** when `Write_en && Full`, the byte is dropped, no pointer or count changes, and `Overflow` is set.
- **Overflow clear:** `Clear_overflow` clears `Overflow`. If a write is dropped in the same cycle, set wins.
- **Pop:** occurs only on the S_FEED_IDLE → S_FEED_REQ transition. `TX_data` ← FIFO head and the read pointer increments.
- **Count update:** a write and a pop in the same cycle leave `Count` unchanged. Otherwise `Count` increments by 1 on a write and decrements by 1 on a pop.
- **Sequencer states:**
  - S_FEED_IDLE: `Start`=0. If `Count`≠0 and `TX_empty`=1, pop and go to S_FEED_REQ.
  - S_FEED_REQ: `Start`=1. Remain until `TX_empty`=0, which means the controller has latched the request. Then drop `Start` and go to S_FEED_WAIT.
  - S_FEED_WAIT: `Start`=0. Remain until `TX_empty`=1, which marks the stop bit. Then go to S_FEED_IDLE.
- **Data hold:** `TX_data` is registered and changes only on a pop. It is stable from the start bit through the last data bit, because the controller samples `TX_data` directly while shifting.
- **Unreachable state:** any unreachable state returns to S_FEED_IDLE with `Start`=0.

## Timing
- **Reset values:**
  - `Start`=0, `TX_data`=8'h00.
  - `Count`=0, `Full`=0, `Overflow`=0, `Busy`=0.
  - Both pointers 0, state S_FEED_IDLE.
  - FIFO memory contents are don't-care.
- **Write visibility:** a write accepted at edge N is reflected in `Count`/`Full` after edge N.
- **Write-to-request latency:** with the FIFO empty and the controller idle, a write at edge N raises `Start` and updates `TX_data` after edge N+1.
- **Start duration:** `Start` stays high until the first `TX_empty`=0 is seen. This is typically up to one `TX_clock_enable` period, and has no upper bound.
- **Next pop:** occurs no earlier than one cycle after `TX_empty` returns to 1. Consecutive frames are separated by exactly one stop bit plus one IDLE enable tick of the controller.
- **Simultaneous write and pop with `Count`=16:** `Full` is evaluated before the pop, so the write is dropped and `Overflow` sets.
- **Write to empty FIFO while S_FEED_IDLE with `TX_empty`=1:** no same-cycle bypass. The pop occurs the next cycle.
- **Reset mid-frame:** everything returns to its reset value in one cycle. The controller is reset simultaneously through `~Reset`, so no partial handshake survives.

## Test plan
- Write 8'h55 once into an idle system → `Start` rises 2 cycles later with `TX_data`=8'h55. `Count` goes 1→0 on the pop. The line shows start bit 0, then 1,0,1,0,1,0,1,0, then stop bit 1.
- Burst-write 8'h41..8'h44 on consecutive cycles → `Count` peaks at 3 or 4, and four frames are transmitted in order. `TX_data` never changes while `TX_empty`=0.
- Write 17 bytes back-to-back while the controller is stalled (`TX_empty` forced 0) → `Full`=1 after 16 writes and `Count`=16. The 17th write is dropped and `Overflow`=1.
- Pulse `Clear_overflow` → `Overflow`=0. Repeat `Clear_overflow` in the same cycle as a dropped write → `Overflow` remains 1.
- Write 20 bytes with `Write_en` paced so the FIFO never fills → pointers wrap past 15 and all 20 bytes are transmitted in order, with no overflow.
- Assert `Reset` during the data bits of the second frame → the next cycle shows `Start`=0, `Count`=0, `Busy`=0 and line idle 1. A new write afterward transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo_feeder_if.sv
// Producer/transmitter bundle for uart_tx_fifo_feeder.
// master: the environment (byte producer plus the UART transmit controller's Empty flag).
// slave : the feeder itself. It accepts writes and drives Start/TX_data towards the controller.
interface uart_tx_fifo_feeder_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  Write_en;        // one byte per cycle
  logic [7:0]            Write_data;
  logic                  Full;            // 2^DEPTH_LOG2 bytes stored
  logic [DEPTH_LOG2:0]   Count;           // bytes stored, 0..2^DEPTH_LOG2
  logic                  Overflow;        // sticky: a write was dropped
  logic                  Clear_overflow;
  logic                  TX_empty;        // controller Empty flag
  logic                  Start;           // transmit request
  logic [7:0]            TX_data;         // byte of the current frame
  logic                  Busy;            // sequencer not idle

  modport master (
    output Write_en, Write_data, Clear_overflow, TX_empty,
    input  Full, Count, Overflow, Start, TX_data, Busy
  );

  modport slave (
    input  Write_en, Write_data, Clear_overflow, TX_empty,
    output Full, Count, Overflow, Start, TX_data, Busy
  );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus Start/Empty handshake sequencer feeding a UART transmit controller.
// Ports: Clock_i and Reset_i (synchronous, active high) are the clock and reset.
//        bus is the slave modport: producer writes in, and Start/TX_data go out to the controller.
module uart_tx_fifo_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  Clock_i,
  input  logic                  Reset_i,
  uart_tx_fifo_feeder_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_FEED_IDLE = 2'd0,
    S_FEED_REQ  = 2'd1,
    S_FEED_WAIT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             tx_data_q, tx_data_d;

  logic full;
  logic wr_accept;
  logic pop;
  logic start;

  // Full is taken from the registered count. A write arriving in the same
  // cycle as a pop from a full FIFO is therefore dropped.
  assign full      = (count_q == CNT_FULL);
  assign wr_accept = bus.Write_en && !full;

  // Sequencer: a pop happens only when leaving IDLE. The 2-bit encoding has
  // one unused code, and that code falls back to IDLE with Start low.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    start   = 1'b0;
    case (state_q)
      S_FEED_IDLE: begin
        if ((count_q != '0) && bus.TX_empty) begin
          pop     = 1'b1;
          state_d = S_FEED_REQ;
        end
      end
      S_FEED_REQ: begin
        start = 1'b1;
        // Empty going low means the controller has latched the request.
        if (!bus.TX_empty) state_d = S_FEED_WAIT;
      end
      S_FEED_WAIT: begin
        // Empty returning high marks the stop bit of the frame.
        if (bus.TX_empty) state_d = S_FEED_IDLE;
      end
      default: state_d = S_FEED_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      tx_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A dropped write in the same cycle as a clear leaves the flag set.
    ovf_d = (ovf_q && !bus.Clear_overflow) || (bus.Write_en && full);
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q   <= S_FEED_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Storage has no reset. Occupancy is tracked by count_q alone.
  always_ff @(posedge Clock_i) begin
    if (wr_accept) mem_q[wr_ptr_q] <= bus.Write_data;
  end

  assign bus.Full     = full;
  assign bus.Count    = count_q;
  assign bus.Overflow = ovf_q;
  assign bus.Start    = start;
  assign bus.TX_data  = tx_data_q;
  assign bus.Busy     = (state_q != S_FEED_IDLE);
endmodule
